// File: rtl/ghost_move_requester.sv
// Per-ghost move engine: requests the four neighbour rows from the ghost-map responder, then steps toward a target tile.
// Optional random "frightened" steering is compiled in with `define GHOST_FRIGHT_EN.
module ghost_move_requester #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int START_X    = 15,
    parameter int START_Y    = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
`ifdef GHOST_FRIGHT_EN
    input  logic                  fright,
`endif
    input  logic [ADDR_WIDTH-1:0] target_x,
    input  logic [ADDR_WIDTH-1:0] target_y,
    input  logic                  ready_in,
    input  logic                  done_in,
    input  logic [DATA_WIDTH-1:0] r_data_up,
    input  logic [DATA_WIDTH-1:0] r_data_down,
    input  logic [DATA_WIDTH-1:0] r_data_left,
    input  logic [DATA_WIDTH-1:0] r_data_right,
    output logic                  start,
    output logic [ADDR_WIDTH-1:0] r_addr_up,
    output logic [ADDR_WIDTH-1:0] r_addr_down,
    output logic [ADDR_WIDTH-1:0] r_addr_left,
    output logic [ADDR_WIDTH-1:0] r_addr_right,
    output logic [ADDR_WIDTH-1:0] ghost_x,
    output logic [ADDR_WIDTH-1:0] ghost_y,
    output logic [1:0]            dir,
    output logic                  move_valid,
    output logic                  blocked,
    output logic                  busy
);

    // Two spare bits: neighbour coordinates can reach -1 or 2^ADDR_WIDTH, and the summed cost cannot wrap.
    localparam int CW = ADDR_WIDTH + 2;
    localparam logic signed [CW-1:0] ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL, S_DECIDE} state_t;

    state_t                r_state;
    logic                  r_start;
    logic                  r_move_valid;
    logic                  r_blocked;
    logic                  r_busy;
    logic [ADDR_WIDTH-1:0] r_ghost_x;
    logic [ADDR_WIDTH-1:0] r_ghost_y;
    logic [1:0]            r_dir;

    logic [ADDR_WIDTH-1:0] w_x_left;
    logic [ADDR_WIDTH-1:0] w_x_right;
    logic [3:0]            w_open;
    logic [3:0]            w_cand;
    logic [1:0]            w_rev;
    logic signed [CW-1:0]  w_cx, w_cy, w_tx, w_ty;
    logic [CW-1:0]         w_cost [4];
    logic [CW-1:0]         w_best;
    logic                  w_found;
    logic                  w_any;
    logic [1:0]            w_choice;
    logic [ADDR_WIDTH-1:0] w_next_x;
    logic [ADDR_WIDTH-1:0] w_next_y;
    logic                  w_unused;

    // ready_in is status only: start is held until done_in regardless of it.
    assign w_unused = ready_in;

    assign r_addr_up    = r_ghost_y - ADDR_WIDTH'(1);
    assign r_addr_down  = r_ghost_y + ADDR_WIDTH'(1);
    assign r_addr_left  = r_ghost_y;
    assign r_addr_right = r_ghost_y;

    assign w_x_left  = r_ghost_x - ADDR_WIDTH'(1);
    assign w_x_right = r_ghost_x + ADDR_WIDTH'(1);

    // Direction index order 0 up, 1 left, 2 down, 3 right doubles as the tie-break priority.
    assign w_open = {r_data_right[w_x_right], r_data_down[r_ghost_x],
                     r_data_left[w_x_left],   r_data_up[r_ghost_x]};
    assign w_rev  = r_dir ^ 2'd2;

    assign w_cx = $signed({2'b00, r_ghost_x});
    assign w_cy = $signed({2'b00, r_ghost_y});
    assign w_tx = $signed({2'b00, target_x});
    assign w_ty = $signed({2'b00, target_y});

    function automatic logic [CW-1:0] abs_diff(input logic signed [CW-1:0] a,
                                               input logic signed [CW-1:0] b);
        logic signed [CW-1:0] d;
        d = a - b;
        return d[CW-1] ? CW'(-d) : CW'(d);
    endfunction

`ifdef GHOST_FRIGHT_EN
    logic [7:0] r_lfsr;
    logic [1:0] w_idx;
    logic       w_rfound;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_lfsr <= 8'hA5;
        else        r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
`endif

    // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        w_cost[0] = abs_diff(w_cx, w_tx)       + abs_diff(w_cy - ONE, w_ty);
        w_cost[1] = abs_diff(w_cx - ONE, w_tx) + abs_diff(w_cy, w_ty);
        w_cost[2] = abs_diff(w_cx, w_tx)       + abs_diff(w_cy + ONE, w_ty);
        w_cost[3] = abs_diff(w_cx + ONE, w_tx) + abs_diff(w_cy, w_ty);

        w_cand = w_open & ~(4'b0001 << w_rev);
        if (w_cand == 4'b0000) w_cand = w_open & (4'b0001 << w_rev);
        w_any = |w_cand;

        w_choice = r_dir;
        w_best   = '0;
        w_found  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (w_cand[i] && (!w_found || w_cost[i] < w_best)) begin
                w_best   = w_cost[i];
                w_choice = 2'(i);
                w_found  = 1'b1;
            end
        end
`ifdef GHOST_FRIGHT_EN
        w_idx    = 2'd0;
        w_rfound = 1'b0;
        if (fright) begin
            for (int k = 0; k < 4; k++) begin
                w_idx = r_lfsr[1:0] + 2'(k);
                if (!w_rfound && w_cand[w_idx]) begin
                    w_choice = w_idx;
                    w_rfound = 1'b1;
                end
            end
        end
`endif

        w_next_x = r_ghost_x;
        w_next_y = r_ghost_y;
        case (w_choice)
            2'd0:    w_next_y = r_addr_up;
            2'd1:    w_next_x = w_x_left;
            2'd2:    w_next_y = r_addr_down;
            default: w_next_x = w_x_right;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_start      <= 1'b0;
            r_move_valid <= 1'b0;
            r_blocked    <= 1'b0;
            r_busy       <= 1'b0;
            r_ghost_x    <= ADDR_WIDTH'(START_X);
            r_ghost_y    <= ADDR_WIDTH'(START_Y);
            r_dir        <= 2'd1;
        end else begin
            r_move_valid <= 1'b0;
            r_blocked    <= 1'b0;
            case (r_state)
                S_IDLE: if (tick) begin
                    r_state <= S_REQ;
                    r_start <= 1'b1;
                    r_busy  <= 1'b1;
                end
                S_REQ: if (done_in) begin
                    r_state <= S_REL;
                    r_start <= 1'b0;
                end
                S_REL: r_state <= S_DECIDE;
                S_DECIDE: begin
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                    r_move_valid <= 1'b1;
                    if (w_any) begin
                        r_ghost_x <= w_next_x;
                        r_ghost_y <= w_next_y;
                        r_dir     <= w_choice;
                    end else begin
                        r_blocked <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_start <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign start      = r_start;
    assign ghost_x    = r_ghost_x;
    assign ghost_y    = r_ghost_y;
    assign dir        = r_dir;
    assign move_valid = r_move_valid;
    assign blocked    = r_blocked;
    assign busy       = r_busy;

endmodule

// File: tb/tb_ghost_move_requester.sv
// Directed bench for ghost_move_requester: a small maze table feeds a behavioural idle->load->done responder.
module tb_ghost_move_requester;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tick = 1'b0;
    logic [AW-1:0] target_x = '0;
    logic [AW-1:0] target_y = '0;
    logic          ready_in, done_in;
    logic [DW-1:0] r_data_up, r_data_down, r_data_left, r_data_right;
    logic          start;
    logic [AW-1:0] r_addr_up, r_addr_down, r_addr_left, r_addr_right;
    logic [AW-1:0] ghost_x, ghost_y;
    logic [1:0]    dir;
    logic          move_valid, blocked, busy;

    logic [DW-1:0] maze [32];
    logic [1:0]    rs;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    assign r_data_up    = maze[r_addr_up];
    assign r_data_down  = maze[r_addr_down];
    assign r_data_left  = maze[r_addr_left];
    assign r_data_right = maze[r_addr_right];
    assign ready_in     = (rs == 2'd0);
    assign done_in      = (rs == 2'd2);

    // Responder: idle -> load -> done, back to idle once start drops.
    always @(posedge clk or negedge reset) begin
        if (!reset) rs <= 2'd0;
        else case (rs)
            2'd0:    if (start) rs <= 2'd1;
            2'd1:    rs <= 2'd2;
            2'd2:    if (!start) rs <= 2'd0;
            default: rs <= 2'd0;
        endcase
    end

    ghost_move_requester #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .START_X(15), .START_Y(11)
    ) u_dut (
        .clk(clk), .reset(reset), .tick(tick),
`ifdef GHOST_FRIGHT_EN
        .fright(1'b0),
`endif
        .target_x(target_x), .target_y(target_y),
        .ready_in(ready_in), .done_in(done_in),
        .r_data_up(r_data_up), .r_data_down(r_data_down),
        .r_data_left(r_data_left), .r_data_right(r_data_right),
        .start(start),
        .r_addr_up(r_addr_up), .r_addr_down(r_addr_down),
        .r_addr_left(r_addr_left), .r_addr_right(r_addr_right),
        .ghost_x(ghost_x), .ghost_y(ghost_y), .dir(dir),
        .move_valid(move_valid), .blocked(blocked), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_maze();
        for (int i = 0; i < 32; i++) maze[i] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        tick  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge where move_valid is seen (or after the budget runs out).
    task automatic move(input logic [AW-1:0] tx, input logic [AW-1:0] ty);
        int cyc;
        tick = 1'b1; target_x = tx; target_y = ty;
        @(negedge clk);
        tick = 1'b0;
        cyc  = 1;
        while (move_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("move_latency", cyc, 6);
    endtask

    initial begin
        int mv_count;
        clear_maze();
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Idle after reset: {x, y, dir, start, busy, move_valid, blocked}.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("reset_idle", {ghost_x, ghost_y, dir, start, busy, move_valid, blocked},
                  {5'd15, 5'd11, 2'd1, 4'b0000});
        end

        // Open corridor on row 11, detailed latency plus ticks dropped while busy.
        clear_maze();
        maze[11] = '1;
        tick = 1'b1; target_x = 5'd0; target_y = 5'd11;
        mv_count = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            tick = (c >= 2 && c <= 5);
            if (c == 1) begin
                check("addr_up",    r_addr_up,    5'd10);
                check("addr_down",  r_addr_down,  5'd12);
                check("addr_left",  r_addr_left,  5'd11);
                check("addr_right", r_addr_right, 5'd11);
                check("busy_c1",    busy,         1'b1);
            end
            if (c <= 4) check("start_window", start, (c <= 3));
            if (c == 5) check("no_mv_c5", move_valid, 1'b0);
            if (c == 6) begin
                check("corr_mv",      move_valid, 1'b1);
                check("corr_x",       ghost_x,    5'd14);
                check("corr_y",       ghost_y,    5'd11);
                check("corr_dir",     dir,        2'd1);
                check("corr_blocked", blocked,    1'b0);
                check("corr_busy",    busy,       1'b0);
            end
            if (move_valid === 1'b1) mv_count++;
        end
        check("single_move_valid", mv_count, 1);

        // Up and left open; target above chooses up.
        do_reset();
        clear_maze();
        maze[10] = 32'h0000_8000;
        maze[11] = 32'h0000_4000;
        move(5'd15, 5'd0);
        check("up_pos", {ghost_x, ghost_y, dir}, {5'd15, 5'd10, 2'd0});

        // Same maze, target along the row chooses left.
        do_reset();
        move(5'd0, 5'd11);
        check("left_pos", {ghost_x, ghost_y, dir}, {5'd14, 5'd11, 2'd1});

        // Equal cost (1 each) for up and left: up has priority.
        do_reset();
        move(5'd14, 5'd10);
        check("tie_pos", {ghost_x, ghost_y, dir}, {5'd15, 5'd10, 2'd0});

        // Dead end: only the reverse (right) is open.
        do_reset();
        clear_maze();
        maze[11] = 32'h0001_0000;
        move(5'd0, 5'd11);
        check("reverse_pos", {ghost_x, ghost_y, dir, blocked}, {5'd16, 5'd11, 2'd3, 1'b0});

        // Fully enclosed: blocked pulse, nothing moves.
        do_reset();
        clear_maze();
        move(5'd0, 5'd0);
        check("blocked_pos", {ghost_x, ghost_y, dir, blocked}, {5'd15, 5'd11, 2'd1, 1'b1});
        @(negedge clk);
        check("blocked_pulse_end", {move_valid, blocked}, 2'b00);

        // Reset while in S_REQ: start must fall without a clock edge.
        do_reset();
        clear_maze();
        maze[11] = '1;
        tick = 1'b1; target_x = 5'd0; target_y = 5'd11;
        @(negedge clk);
        tick = 1'b0;
        check("start_before_reset", start, 1'b1);
        #2 reset = 1'b0;
        #1 check("start_async_drop", {start, busy}, 2'b00);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        move(5'd0, 5'd11);
        check("post_reset_move", {ghost_x, ghost_y, dir, blocked}, {5'd14, 5'd11, 2'd1, 1'b0});

        // Walk up column 15 then left along row 0, back-to-back ticks, then wrap from (0,0).
        do_reset();
        clear_maze();
        maze[0] = 32'h8000_FFFF;
        for (int r = 1; r <= 11; r++) maze[r] = 32'h0000_8000;
        for (int m = 0; m < 26; m++) begin
            move(5'd0, 5'd0);
            if (m == 10) check("col_top", {ghost_x, ghost_y, dir}, {5'd15, 5'd0, 2'd0});
        end
        check("origin", {ghost_x, ghost_y, dir}, {5'd0, 5'd0, 2'd1});
        check("wrap_addr_up", r_addr_up, 5'd31);
        check("wrap_addr_down", r_addr_down, 5'd1);
        move(5'd0, 5'd0);
        check("wrap_pos", {ghost_x, ghost_y, dir, blocked}, {5'd31, 5'd0, 2'd1, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
